// File: rtl/rr_select_arbiter_pkg.sv
// Shared types and constants for the round-robin select arbiter.
package rr_select_arbiter_pkg;

    localparam int N_REQ  = 8;
    localparam int HOLD_W = 5;
    localparam int GAP_W  = 3;

    localparam logic [N_REQ-1:0] SEL_IDLE = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Active-low one-hot decode of an owner index onto the select lines.
    function automatic logic [N_REQ-1:0] sel_decode(input logic [2:0] idx);
        logic [N_REQ-1:0] onehot;
        onehot      = '0;
        onehot[idx] = 1'b1;
        return ~onehot;
    endfunction

endpackage

// File: rtl/rr_select_arbiter_if.sv
// Requester-side bus of the select arbiter.
//
// Handshake: a requester holds req[k] high for as long as it wants the
// resource. Ownership begins in the first cycle grant_valid=1 with
// grant_idx=k and lasts until the arbiter drops grant_valid. The owner ends
// its window by asserting done for one cycle (or by dropping req[k]); done is
// only looked at while a grant is held and is ignored otherwise.
interface rr_select_arbiter_if;
    import rr_select_arbiter_pkg::*;

    logic             enable;
    logic [N_REQ-1:0] req;
    logic             done;
    logic [N_REQ-1:0] grant_n;
    logic [2:0]       grant_idx;
    logic             grant_valid;
    logic             timeout;

    modport master (
        output enable, req, done,
        input  grant_n, grant_idx, grant_valid, timeout
    );

    modport slave (
        input  enable, req, done,
        output grant_n, grant_idx, grant_valid, timeout
    );

endinterface

// File: rtl/rr_select_arbiter_pick.sv
// Round-robin pick: first set request at or above ptr, wrapping 7 -> 0.
module rr_priority_pick
    import rr_select_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [2:0]       ptr,
    output logic             found,
    output logic [2:0]       idx
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [2:0]         off;

    // Rotate so ptr lands at bit 0, find the lowest set bit, rotate back.
    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[N_REQ-1:0];
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = 3'(i);
            end
        end
        found = |req;
        idx   = ptr + off;
    end

endmodule

// File: rtl/rr_select_arbiter.sv
// Round-robin owner of an 8-way active-low select, with held grant windows,
// a hold timeout and a break-before-make gap after every release.
module rr_select_arbiter
    import rr_select_arbiter_pkg::*;
#(
    parameter int MAX_HOLD   = 16,
    parameter int GAP_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rr_select_arbiter_if.slave   bus,
    output state_t               dbg_state
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    state_t             state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [2:0]         ptr_q, ptr_d;
    logic [N_REQ-1:0]   grant_n_q, grant_n_d;
    logic [2:0]         idx_q, idx_d;
    logic               valid_q, valid_d;
    logic               timeout_q, timeout_d;

    logic               pick_found;
    logic [2:0]         pick_idx;

    rr_priority_pick u_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Next-state, counters and registered outputs; defaults hold everything
    // except the timeout pulse, which is high only on a forced release.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        gap_d     = gap_q;
        ptr_d     = ptr_q;
        grant_n_d = grant_n_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.enable && pick_found) begin
                    state_d   = ST_GRANT;
                    idx_d     = pick_idx;
                    grant_n_d = sel_decode(pick_idx);
                    valid_d   = 1'b1;
                    hold_d    = '0;
                end
            end
            ST_GRANT: begin
                if (hold_q != '1) begin
                    hold_d = hold_q + 1'b1;
                end
                if (bus.done || !bus.req[idx_q] || !bus.enable || (hold_q == HOLD_LAST)) begin
                    // Only a pure hold expiry counts as a timeout.
                    timeout_d = !bus.done && bus.req[idx_q] && bus.enable;
                    state_d   = ST_GAP;
                    grant_n_d = SEL_IDLE;
                    valid_d   = 1'b0;
                    ptr_d     = idx_q + 1'b1;
                    gap_d     = '0;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                grant_n_d = SEL_IDLE;
                valid_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset forces the selects high at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            hold_q    <= '0;
            gap_q     <= '0;
            ptr_q     <= '0;
            grant_n_q <= SEL_IDLE;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            gap_q     <= gap_d;
            ptr_q     <= ptr_d;
            grant_n_q <= grant_n_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.grant_n     = grant_n_q;
    assign bus.grant_idx   = idx_q;
    assign bus.grant_valid = valid_q;
    assign bus.timeout     = timeout_q;
    assign dbg_state       = state_q;

endmodule
